elastic_register_stage: RTL and testbench
=========================================

Name: elastic_register_stage

Overview:
- Backpressured counterpart of the plain flit/flag pipeline register used on router input and output stages.
- Carries a flit plus a configurable flag vector across a link segment using a valid/ready handshake; the ready signal flows upstream.
- A 2-entry skid buffer keeps full throughput (1 flit/cycle) while in_ready is driven directly from a flop, so no combinational path runs from out_ready to in_ready.
- Used where a router port or NI must stall the link, e.g. a BE channel feeding a local buffer.

Parameters:
- FLIT_WIDTH, 32, width of the flit payload.
- FLAGS, 2, width of the sideband flag vector (e.g. first/last); must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  FLIT_WIDTH  upstream flit.
- in_flags  in  FLAGS  upstream flags.
- in_valid  in  1  upstream flit/flags valid.
- in_ready  out  1  stage can accept; registered output.
- out_flit  out  FLIT_WIDTH  downstream flit; equals main entry data.
- out_flags  out  FLAGS  downstream flags; equals main entry flags.
- out_valid  out  1  main entry holds a flit.
- out_ready  in  1  downstream accepts.
- occupancy  out  2  number of stored flits (0..2), for debug/verification.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. A transfer occurs on a rising clk edge when valid && ready on that side.
- FSM states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2). in_ready_q = (next_state != FULL), registered.
- EMPTY, in accepted -> main <= in, go to ONE. Otherwise stay EMPTY.
- ONE:
  - in and out both accepted -> main <= in, stay ONE.
  - in only -> skid <= in, go to FULL.
  - out only -> go to EMPTY.
  - neither -> hold.
- FULL: in_ready = 0, so in_valid is ignored.
  - out accepted -> main <= skid, go to ONE.
  - otherwise hold.
- Latency: 1 cycle from input acceptance to out_valid when empty. Throughput: 1 flit/cycle sustained with out_ready held high.
- Stability: while out_valid && !out_ready, out_flit and out_flags hold constant. out_valid never drops without a transfer.
- Ordering: strict FIFO; no flit is dropped or duplicated.
- Reset (rst high on a clk edge):
  - state -> EMPTY, out_valid = 0, occupancy = 0, in_ready = 1.
  - Flags of both entries = 0. Flit data registers are not reset; out_flit is don't-care while out_valid = 0.
- Reset mid-operation: all stored flits are discarded. in_valid/out_ready sampled in a reset cycle cause no transfer.
- out_ready while out_valid = 0: no effect.
- in_valid deasserted by upstream without a transfer: legal; nothing stored.

Decomposition:
- State enum (EMPTY/ONE/FULL) goes in the shared NoC package as a typedef, reusable by other elastic stages.
- No package constants beyond that; widths come from parameters.
- No sub-module: the two entries are small and written inline. A single-entry flop helper is not warranted.

Test Plan:
- Pass-through: out_ready = 1, flits 0x1..0x8 on consecutive cycles, flags = 2'b01 on the first and 2'b10 on the last -> each appears 1 cycle later, back to back, flags intact, occupancy <= 1.
- Stall fill: out_ready = 0, send 0xA, 0xB -> in_ready drops the cycle after 0xB is accepted. out_flit stays 0xA while 0xC is held on the input. Raise out_ready -> order is 0xA, 0xB, then 0xC, with none lost.
- Random handshake: 1000 cycles of random in_valid/out_ready at 50% -> scoreboard matches in order. in_ready never low unless occupancy = 2 or in a reset cycle. Stability assertion holds.
- Simultaneous transfer in ONE: occupancy 1 with 0x5 stored, in 0x6 and out_ready both high -> 0x5 leaves, 0x6 in main, occupancy stays 1.
- Drain from FULL: occupancy 2 with 0x11, 0x22 stored, out_ready = 1 for 2 cycles -> out 0x11 then 0x22. in_ready = 1 after the first drain. Then out_valid = 0, occupancy = 0.
- Reset mid-operation: occupancy 2, assert rst for 1 cycle -> out_valid = 0, out_flags = 0, in_ready = 1, occupancy = 0. The next flit 0x33 emerges alone after 1 cycle.

Source files
------------

// File: rtl/elastic_register_stage_pkg.sv
// Shared NoC types for elastic (valid/ready) pipeline stages.
// Holds the state encoding common to the 2-entry skid-buffer stages.
package elastic_register_stage_pkg;

  // Number of flits held by a 2-entry elastic stage.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } elastic_state_e;

endpackage

// File: rtl/elastic_register_stage.sv
// Backpressured flit/flag pipeline register with a 2-entry skid buffer.
// in_ready_o comes straight from a flop, so out_ready_i never reaches it combinationally.
module elastic_register_stage
  import elastic_register_stage_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned FLAGS      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit_i,
  input  logic [FLAGS-1:0]      in_flags_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [FLIT_WIDTH-1:0] out_flit_o,
  output logic [FLAGS-1:0]      out_flags_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            occupancy_o
);

  elastic_state_e state_q, state_d;
  logic           in_ready_q, in_ready_d;

  logic [FLIT_WIDTH-1:0] main_flit_q, skid_flit_q;
  logic [FLAGS-1:0]      main_flags_q, skid_flags_q;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid_o = (state_q != StEmpty);
  assign in_fire     = in_valid_i && in_ready_q;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = StFull;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the downstream side can move.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      in_ready_q   <= 1'b1;
      main_flags_q <= '0;
      skid_flags_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      if (load_main_in) begin
        main_flags_q <= in_flags_i;
      end else if (load_main_skid) begin
        main_flags_q <= skid_flags_q;
      end
      if (load_skid) begin
        skid_flags_q <= in_flags_i;
      end
    end
  end

  // Flit payload is left unreset; it is only meaningful while out_valid_o is high.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_flit_q <= in_flit_i;
    end else if (load_main_skid) begin
      main_flit_q <= skid_flit_q;
    end
    if (load_skid) begin
      skid_flit_q <= in_flit_i;
    end
  end

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      StOne:   occupancy_o = 2'd1;
      StFull:  occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign in_ready_o  = in_ready_q;
  assign out_flit_o  = main_flit_q;
  assign out_flags_o = main_flags_q;

endmodule

// File: tb/tb_elastic_register_stage.sv
// Directed and random scoreboard bench for elastic_register_stage.
module tb_elastic_register_stage;

  localparam int unsigned FW = 32;
  localparam int unsigned FL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_flit;
  logic [FL-1:0] in_flags;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic [FL-1:0] out_flags;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FL+FW-1:0] sb[$];
  logic             stall_prev = 1'b0;
  logic [FL+FW-1:0] prev_out;

  always #5 clk = ~clk;

  elastic_register_stage #(
    .FLIT_WIDTH(FW),
    .FLAGS     (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit_i  (in_flit),
    .in_flags_i (in_flags),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_flit_o (out_flit),
    .out_flags_o(out_flags),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .occupancy_o(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, score at negedge+1, return just after posedge with
  // inputs idled so post-step checks see the updated state.
  task automatic step(input logic iv, input logic [FW-1:0] f, input logic [FL-1:0] fl,
                      input logic ordy);
    logic [FL+FW-1:0] exp;
    @(negedge clk);
    in_valid  = iv;
    in_flit   = f;
    in_flags  = fl;
    out_ready = ordy;
    #1;
    chk("rdy_vs_occ", {63'd0, in_ready}, {63'd0, occupancy != 2'd2});
    if (stall_prev) begin
      chk("stable_valid", {63'd0, out_valid}, 64'd1);
      chk("stable_data", {30'd0, out_flags, out_flit}, {30'd0, prev_out});
    end
    if (out_valid && out_ready) begin
      chk("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("sb_out", {30'd0, out_flags, out_flit}, {30'd0, exp});
      end
    end
    if (in_valid && in_ready) sb.push_back({in_flags, in_flit});
    stall_prev = out_valid && !out_ready;
    prev_out   = {out_flags, out_flit};
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Reset cycle with both handshakes asserted: nothing may transfer.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_flit   = 32'hDEAD_BEEF;
    in_flags  = 2'b11;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [1:0] occ,
                           input logic rdy);
    chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
    chk({tag, "_occ"}, {62'd0, occupancy}, {62'd0, occ});
    chk({tag, "_ready"}, {63'd0, in_ready}, {63'd0, rdy});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    in_flags  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    chk_state("reset", 1'b0, 2'd0, 1'b1);
    chk("reset_flags", {62'd0, out_flags}, 64'd0);

    // Pass-through, back to back.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, FW'(i), (i == 1) ? 2'b01 : ((i == 8) ? 2'b10 : 2'b00), 1'b1);
      chk("pt_valid", {63'd0, out_valid}, 64'd1);
      chk("pt_flit", {32'd0, out_flit}, 64'(i));
      chk("pt_occ_le1", {63'd0, occupancy <= 2'd1}, 64'd1);
    end
    step(1'b0, '0, '0, 1'b1);
    chk_state("pt_end", 1'b0, 2'd0, 1'b1);
    chk("pt_sb_empty", 64'(sb.size()), 64'd0);

    // Stall fill, then release.
    step(1'b1, 32'hA, 2'b01, 1'b0);
    step(1'b1, 32'hB, 2'b00, 1'b0);
    chk_state("fill", 1'b1, 2'd2, 1'b0);
    chk("fill_flit", {32'd0, out_flit}, 64'hA);
    step(1'b1, 32'hC, 2'b10, 1'b0);
    step(1'b1, 32'hC, 2'b10, 1'b0);
    chk("fill_hold", {32'd0, out_flit}, 64'hA);
    step(1'b1, 32'hC, 2'b10, 1'b1);
    chk_state("fill_drain1", 1'b1, 2'd1, 1'b1);
    step(1'b1, 32'hC, 2'b10, 1'b1);
    chk("fill_c_main", {32'd0, out_flit}, 64'hC);
    step(1'b0, '0, '0, 1'b1);
    chk_state("fill_end", 1'b0, 2'd0, 1'b1);
    chk("fill_sb_empty", 64'(sb.size()), 64'd0);

    // Simultaneous transfer in ONE.
    step(1'b1, 32'h5, 2'b01, 1'b0);
    chk_state("sim_pre", 1'b1, 2'd1, 1'b1);
    step(1'b1, 32'h6, 2'b10, 1'b1);
    chk_state("sim_post", 1'b1, 2'd1, 1'b1);
    chk("sim_flit", {32'd0, out_flit}, 64'h6);
    chk("sim_flags", {62'd0, out_flags}, 64'd2);
    step(1'b0, '0, '0, 1'b1);

    // Drain from FULL.
    step(1'b1, 32'h11, 2'b01, 1'b0);
    step(1'b1, 32'h22, 2'b10, 1'b0);
    chk_state("drain_full", 1'b1, 2'd2, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    chk_state("drain1", 1'b1, 2'd1, 1'b1);
    chk("drain1_flit", {32'd0, out_flit}, 64'h22);
    step(1'b0, '0, '0, 1'b1);
    chk_state("drain2", 1'b0, 2'd0, 1'b1);

    // Reset mid-operation.
    step(1'b1, 32'h44, 2'b11, 1'b0);
    step(1'b1, 32'h55, 2'b11, 1'b0);
    chk_state("mid_full", 1'b1, 2'd2, 1'b0);
    do_reset();
    chk_state("mid_rst", 1'b0, 2'd0, 1'b1);
    chk("mid_rst_flags", {62'd0, out_flags}, 64'd0);
    step(1'b1, 32'h33, 2'b01, 1'b1);
    chk_state("post_rst", 1'b1, 2'd1, 1'b1);
    chk("post_rst_flit", {32'd0, out_flit}, 64'h33);
    step(1'b0, '0, '0, 1'b1);
    chk_state("post_rst_end", 1'b0, 2'd0, 1'b1);
    chk("post_rst_sb", 64'(sb.size()), 64'd0);

    // Random handshake.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(1)), FW'($urandom), FL'($urandom), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 4 && sb.size() != 0; i++) begin
      step(1'b0, '0, '0, 1'b1);
    end
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    chk_state("rand_end", 1'b0, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
